// File: rtl/vload_writeback.sv
// Load sequencer: fetches one word (scalar dst) or V/N words (vector dst),
// assembles them and writes the register bank, stalling the ALU on collision.
module vload_writeback #(
  parameter int V  = 128,
  parameter int N  = 32,
  parameter int M  = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [M-1:0]  dst,
  input  logic [AW-1:0] base,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [N-1:0]  mem_rdata,
  input  logic          alu_we,
  input  logic [M-1:0]  alu_wa,
  input  logic [V-1:0]  alu_wd,
  output logic          alu_stall,
  output logic          we3,
  output logic [M-1:0]  wa3,
  output logic [V-1:0]  wd3
);

  localparam int LANES_MAX = V / N;
  localparam int CW        = $clog2(LANES_MAX) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t          state, state_nxt;
  logic [M-1:0]    dst_q;
  logic [AW-1:0]   base_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   lanes;
  logic [V-1:0]    buf_q;
  logic            take_ack;
  logic            last_ack;

  assign take_ack = (state == FETCH) && mem_ack;
  assign last_ack = take_ack && (cnt == lanes - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    alu_stall = 1'b0;
    we3       = alu_we;
    wa3       = alu_wa;
    wd3       = alu_wd;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_q + (AW'(cnt) << 2);
        if (last_ack) state_nxt = WRITE;
      end
      WRITE: begin
        // load write owns the port; ALU holds its request one more cycle
        busy      = 1'b1;
        done      = 1'b1;
        we3       = 1'b1;
        wa3       = dst_q;
        wd3       = buf_q;
        alu_stall = alu_we;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q  <= '0;
      base_q <= '0;
      cnt    <= '0;
      lanes  <= '0;
      buf_q  <= '0;
    end else if (state == IDLE && start) begin
      dst_q  <= dst;
      base_q <= base;
      cnt    <= '0;
      buf_q  <= '0;
      lanes  <= (int'(dst) > 11) ? CW'(LANES_MAX) : CW'(1);
    end else if (take_ack) begin
      for (int i = 0; i < LANES_MAX; i++) begin
        if (cnt == CW'(i)) buf_q[i*N +: N] <= mem_rdata;
      end
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_vload_writeback.sv
// Bench for vload_writeback: directed scenarios plus randomized loads checked
// against a lane-list model of the expected addresses and assembled data.
module tb_vload_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   dst;
  logic [31:0]  base;
  logic         busy, done, mem_req, mem_ack, alu_stall, we3, alu_we;
  logic [31:0]  mem_addr, mem_rdata;
  logic [3:0]   alu_wa, wa3;
  logic [127:0] alu_wd, wd3;

  int checks   = 0;
  int failures = 0;

  vload_writeback dut (
    .clk(clk), .rst(rst), .start(start), .dst(dst), .base(base),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_we(alu_we),
    .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_stall(alu_stall),
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One load through the DUT; expectations come from the lane list dat[].
  task automatic do_load(input logic [3:0] d, input logic [31:0] b,
                         input logic [31:0] dat [4], input int wmin, input int wmax,
                         input bit coll, input bit sbusy);
    int           lanes;
    int           w;
    logic [127:0] exp_wd;
    logic [127:0] alu_hold;
    logic [31:0]  ea;
    lanes  = (d > 11) ? 4 : 1;
    exp_wd = '0;
    for (int i = 0; i < lanes; i++) exp_wd[i*32 +: 32] = dat[i];

    start = 1'b1; dst = d; base = b; alu_we = 1'b0; mem_ack = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_mem_req", mem_req, 0);
    tick;
    start = 1'b0;
    dst   = 4'($urandom);
    base  = $urandom;
    for (int i = 0; i < lanes; i++) begin
      w  = int'($urandom_range(wmax, wmin));
      ea = b + 32'(4 * i);
      for (int k = 0; k <= w; k++) begin
        if (sbusy && i == 0 && k == 0) begin
          start = 1'b1; dst = 4'd2;
        end else start = 1'b0;
        alu_we    = 1'($urandom);
        alu_wa    = 4'($urandom);
        alu_wd    = {$urandom, $urandom, $urandom, $urandom};
        mem_ack   = (k == w);
        mem_rdata = (k == w) ? dat[i] : $urandom;
        #1;
        chk("fetch_req", mem_req, 1);
        chk("fetch_addr", mem_addr, ea);
        chk("fetch_busy", busy, 1);
        chk("fetch_done", done, 0);
        chk("pass_we", we3, alu_we);
        chk("pass_wa", wa3, alu_wa);
        chk("pass_wd", wd3, alu_wd);
        chk("pass_stall", alu_stall, 0);
        tick;
      end
    end
    mem_ack  = 1'b0;
    start    = sbusy;
    dst      = 4'd2;
    alu_we   = coll;
    alu_wa   = 4'd5;
    alu_hold = {$urandom, $urandom, $urandom, $urandom};
    alu_wd   = alu_hold;
    #1;
    chk("wr_we", we3, 1);
    chk("wr_wa", wa3, d);
    chk("wr_wd", wd3, exp_wd);
    chk("wr_done", done, 1);
    chk("wr_busy", busy, 1);
    chk("wr_mem_req", mem_req, 0);
    chk("wr_stall", alu_stall, coll);
    tick;
    start = 1'b0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_we", we3, coll);
    chk("post_stall", alu_stall, 0);
    if (coll) begin
      chk("post_alu_wa", wa3, 4'd5);
      chk("post_alu_wd", wd3, alu_hold);
    end
    alu_we = 1'b0;
  endtask

  logic [31:0] dat [4];
  logic [3:0]  rd;

  initial begin
    rst = 1'b1; start = 1'b1; dst = 4'd12; base = 32'h40; mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF; alu_we = 1'b0; alu_wa = '0; alu_wd = '0;
    tick; tick;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", alu_stall, 0);
    chk("rst_we", we3, 0);
    rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
    tick;

    // scalar, immediate ack: WRITE two cycles after start
    dat = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    do_load(4'd3, 32'h100, dat, 0, 0, 1'b0, 1'b0);

    // vector with two wait cycles per word
    dat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_load(4'd13, 32'h200, dat, 2, 2, 1'b0, 1'b0);

    // scalar right after a vector: upper bits must be cleared
    dat = '{$urandom, $urandom, $urandom, $urandom};
    do_load(4'd7, $urandom, dat, 0, 1, 1'b1, 1'b0);

    // address wrap
    dat = '{$urandom, $urandom, $urandom, $urandom};
    do_load(4'd12, 32'hFFFF_FFF8, dat, 0, 0, 1'b0, 1'b0);

    // start while busy (FETCH and WRITE), scalar and vector
    dat = '{$urandom, $urandom, $urandom, $urandom};
    do_load(4'd9, 32'h500, dat, 1, 1, 1'b0, 1'b1);
    dat = '{$urandom, $urandom, $urandom, $urandom};
    do_load(4'd14, 32'h600, dat, 0, 2, 1'b1, 1'b1);

    // reset after two of four acks, with an ack in the reset cycle
    start = 1'b1; dst = 4'd12; base = 32'h300; alu_we = 1'b0;
    tick;
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick;
    mem_rdata = 32'hAAAA_0002;
    tick;
    rst = 1'b1; mem_rdata = 32'hAAAA_0003;
    tick;
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_we", we3, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_addr", mem_addr, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("abort_idle_we", we3, 0);
      chk("abort_idle_busy", busy, 0);
    end
    dat = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    do_load(4'd3, 32'h100, dat, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      rd  = 4'($urandom);
      dat = '{$urandom, $urandom, $urandom, $urandom};
      do_load(rd, $urandom, dat, 0, 3, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
